// File: rtl/usb_kbd_event_queue_pkg.sv
// Shared types, register map, HID usage constants and the usage-to-ASCII
// translation for the keyboard event queue.
package usb_kbd_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SCAN   = ST_SCAN,
        COMMIT = ST_COMMIT
    } state_e;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_MODS   = 2'd2;
    localparam logic [1:0] ADDR_DROPS  = 2'd3;

    localparam logic [1:0] TYP_KEYBOARD = 2'd1;

    localparam logic [7:0] USAGE_NONE     = 8'h00;
    localparam logic [7:0] USAGE_ROLLOVER = 8'h01;
    localparam logic [7:0] USAGE_A        = 8'h04;
    localparam logic [7:0] USAGE_Z        = 8'h1D;
    localparam logic [7:0] USAGE_1        = 8'h1E;
    localparam logic [7:0] USAGE_9        = 8'h26;
    localparam logic [7:0] USAGE_0        = 8'h27;
    localparam logic [7:0] USAGE_ENTER    = 8'h28;
    localparam logic [7:0] USAGE_BKSP     = 8'h2A;
    localparam logic [7:0] USAGE_SPACE    = 8'h2C;

    // One queue entry: {modifiers, usage, ascii}
    localparam int ENTRY_W = 24;

    // Either shift modifier (left bit1, right bit5) selects upper case letters.
    function automatic logic [7:0] usage_to_ascii(input logic [7:0] usage,
                                                  input logic [7:0] mods);
        logic       shift;
        logic [7:0] ch;
        shift = mods[1] | mods[5];
        ch    = 8'h00;
        if (usage >= USAGE_A && usage <= USAGE_Z)
            ch = (shift ? 8'h41 : 8'h61) + (usage - USAGE_A);
        else if (usage >= USAGE_1 && usage <= USAGE_9)
            ch = 8'h31 + (usage - USAGE_1);
        else if (usage == USAGE_0)
            ch = 8'h30;
        else if (usage == USAGE_ENTER)
            ch = 8'h0A;
        else if (usage == USAGE_BKSP)
            ch = 8'h08;
        else if (usage == USAGE_SPACE)
            ch = 8'h20;
        return ch;
    endfunction

endpackage

// File: rtl/usb_kbd_event_queue_if.sv
// CPU-side register bus of the keyboard event queue.
interface usb_kbd_event_queue_if;
    logic        ren;
    logic        wen;
    logic [1:0]  address;
    logic [31:0] data_out;

    modport master (output ren, output wen, output address, input  data_out);
    modport slave  (input  ren, input  wen, input  address, output data_out);
endinterface

// File: rtl/usb_kbd_event_queue_fifo.sv
// Event FIFO: DEPTH x 24-bit entries with push, pop and flush.
module kbd_event_fifo
    import usb_kbd_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [ENTRY_W-1:0]     wdata_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [ENTRY_W-1:0]     rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW:0]        count_q;
    logic               do_push;
    logic               do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push)
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/usb_kbd_event_queue.sv
// Turns HID keyboard reports into a queue of new key-press events
// ({modifiers, usage, ascii}) read by the CPU over a 4-register bus.
module usb_kbd_event_queue
    import usb_kbd_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              report,
    input  logic [1:0]        typ,
    input  logic [7:0]        key_modifiers,
    input  logic [7:0]        key1,
    input  logic [7:0]        key2,
    input  logic [7:0]        key3,
    input  logic [7:0]        key4,
    usb_kbd_event_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic [1:0]        slot_q, slot_d;
    logic              pending_q;
    logic [7:0]        snap_mods_q;
    logic [3:0][7:0]   snap_keys_q;
    logic [7:0]        scan_mods_q;
    logic [3:0][7:0]   scan_keys_q;
    logic              rollover_q;
    logic [3:0][7:0]   prev_keys_q;
    logic              overflow_q;
    logic [7:0]        drop_cnt_q;
    logic [31:0]       data_out_q;

    logic [3:0][7:0]   key_in;
    logic [3:0]        prev_hit;
    logic [3:0]        rollover_hit;
    logic [7:0]        cur_key;
    logic              kbd_report;
    logic              other_report;
    logic              scan_start;
    logic              new_press;
    logic              pop_req;
    logic              flush_req;
    logic              drop;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign key_in       = {key4, key3, key2, key1};
    assign kbd_report   = report && (typ == TYP_KEYBOARD);
    assign other_report = report && (typ != TYP_KEYBOARD);
    assign scan_start   = (state_q == IDLE) && pending_q;
    assign cur_key      = scan_keys_q[slot_q];

    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        assign prev_hit[gi]     = (prev_keys_q[gi] == cur_key);
        assign rollover_hit[gi] = (snap_keys_q[gi] == USAGE_ROLLOVER);
    end

    assign new_press = (state_q == SCAN) && !rollover_q &&
                       (cur_key != USAGE_NONE) && !(|prev_hit);
    assign pop_req   = bus.ren && (bus.address == ADDR_DATA);
    assign flush_req = bus.wen && (bus.address == ADDR_STATUS);
    assign drop      = new_press && fifo_full && !pop_req && !flush_req;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d = SCAN;
                    slot_d  = 2'd0;
                end
            end
            SCAN: begin
                slot_d = slot_q + 2'd1;
                if (slot_q == 2'd3)
                    state_d = COMMIT;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    kbd_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (new_press),
        .wdata_i ({scan_mods_q, cur_key, usage_to_ascii(cur_key, scan_mods_q)}),
        .pop_i   (pop_req),
        .flush_i (flush_req),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            slot_q      <= 2'd0;
            pending_q   <= 1'b0;
            snap_mods_q <= '0;
            snap_keys_q <= '0;
            scan_mods_q <= '0;
            scan_keys_q <= '0;
            rollover_q  <= 1'b0;
            prev_keys_q <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
            data_out_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;

            // A fresh report wins over the pending clear of the scan it races.
            if (kbd_report) begin
                snap_mods_q <= key_modifiers;
                snap_keys_q <= key_in;
                pending_q   <= 1'b1;
            end else if (scan_start) begin
                pending_q   <= 1'b0;
            end

            // The scan works on its own copy so later reports cannot disturb it.
            if (scan_start) begin
                scan_mods_q <= snap_mods_q;
                scan_keys_q <= snap_keys_q;
                rollover_q  <= |rollover_hit;
            end

            if (other_report)
                prev_keys_q <= '0;
            else if (state_q == COMMIT && !rollover_q)
                prev_keys_q <= scan_keys_q;

            if (flush_req) begin
                overflow_q <= 1'b0;
                drop_cnt_q <= '0;
            end else if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF)
                    drop_cnt_q <= drop_cnt_q + 8'd1;
            end

            if (bus.ren) begin
                case (bus.address)
                    ADDR_DATA:   data_out_q <= fifo_empty ? 32'h0 : {1'b1, 7'b0, fifo_rdata};
                    ADDR_STATUS: data_out_q <= {16'b0, 8'(fifo_count), 5'b0,
                                                overflow_q, fifo_full, fifo_empty};
                    ADDR_MODS:   data_out_q <= {24'b0, snap_mods_q};
                    default:     data_out_q <= {24'b0, drop_cnt_q};
                endcase
            end
        end
    end

    assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_usb_kbd_event_queue.sv
// Scoreboard bench: a queue-based reference model predicts every bus read;
// a monitor compares data_out one cycle after each read strobe.
module tb_usb_kbd_event_queue;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       report;
    logic [1:0] typ;
    logic [7:0] key_modifiers, key1, key2, key3, key4;

    usb_kbd_event_queue_if bus ();

    usb_kbd_event_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .report        (report),
        .typ           (typ),
        .key_modifiers (key_modifiers),
        .key1          (key1),
        .key2          (key2),
        .key3          (key3),
        .key4          (key4),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    // Reference model state
    logic [23:0] m_fifo[$];
    logic [7:0]  m_prev[4];
    logic [7:0]  m_mods;
    bit          m_ovf;
    int          m_drops;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", n, act, req);
        end
    endtask

    function automatic logic [7:0] ref_ascii(input logic [7:0] u, input logic [7:0] m);
        string lower = "abcdefghijklmnopqrstuvwxyz";
        string upper = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
        string digits = "1234567890";
        if (u >= 8'h04 && u <= 8'h1d)
            return (m[1] || m[5]) ? upper[int'(u) - 4] : lower[int'(u) - 4];
        if (u >= 8'h1e && u <= 8'h27)
            return digits[int'(u) - 'h1e];
        case (u)
            8'h28:   return 8'h0a;
            8'h2a:   return 8'h08;
            8'h2c:   return 8'h20;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_prev  = '{default: 8'h00};
        m_mods  = 8'h00;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic model_flush();
        m_fifo.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    task automatic model_push(input logic [23:0] e);
        if (m_fifo.size() == DEPTH) begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
        end else begin
            m_fifo.push_back(e);
        end
    endtask

    task automatic model_report(input logic [1:0] t, input logic [7:0] md, input logic [7:0] ks[4]);
        bit held, roll;
        if (t != 2'd1) begin
            m_prev = '{default: 8'h00};
            return;
        end
        m_mods = md;
        roll = 0;
        for (int s = 0; s < 4; s++) if (ks[s] == 8'h01) roll = 1;
        if (roll) return;
        for (int s = 0; s < 4; s++) begin
            held = 0;
            for (int p = 0; p < 4; p++) if (m_prev[p] == ks[s]) held = 1;
            if (ks[s] != 8'h00 && !held)
                model_push({md, ks[s], ref_ascii(ks[s], md)});
        end
        m_prev = ks;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [23:0] e;
        case (a)
            2'd0: begin
                if (m_fifo.size() == 0) return 32'h0;
                e = m_fifo.pop_front();
                return {8'h80, e};
            end
            2'd1: return {16'h0, 8'(m_fifo.size()), 5'b0, m_ovf,
                          m_fifo.size() == DEPTH, m_fifo.size() == 0};
            2'd2: return {24'h0, m_mods};
            default: return {24'h0, 8'(m_drops)};
        endcase
    endfunction

    task automatic issue_read(input logic [1:0] a, input logic [31:0] e, input string n);
        @(negedge clk);
        bus.ren = 1'b1;
        bus.address = a;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(negedge clk);
        bus.ren = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input string n);
        logic [31:0] e;
        e = model_read(a);
        issue_read(a, e, n);
    endtask

    task automatic rd_const(input logic [1:0] a, input logic [31:0] v, input string n);
        void'(model_read(a));
        issue_read(a, v, n);
    endtask

    task automatic wr(input logic [1:0] a);
        if (a == 2'd1) model_flush();
        @(negedge clk);
        bus.wen = 1'b1;
        bus.address = a;
        @(negedge clk);
        bus.wen = 1'b0;
    endtask

    // action: 0 none, 1 pop on the cycle slot 0 is scanned, 2 flush on that cycle
    task automatic send(input logic [1:0] t, input logic [7:0] md,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] a2, input logic [7:0] a3, input int action);
        logic [31:0] e;
        logic [7:0]  ks[4];
        ks = '{a0, a1, a2, a3};
        e = 32'h0;
        if (action == 1) e = model_read(2'd0);
        model_report(t, md, ks);
        if (action == 2) model_flush();
        @(negedge clk);
        report = 1'b1; typ = t; key_modifiers = md;
        key1 = a0; key2 = a1; key3 = a2; key4 = a3;
        @(negedge clk);
        report = 1'b0; typ = 2'($urandom); key_modifiers = 8'($urandom);
        key1 = 8'($urandom); key2 = 8'($urandom); key3 = 8'($urandom); key4 = 8'($urandom);
        @(negedge clk);
        if (action == 1) begin
            bus.ren = 1'b1; bus.address = 2'd0;
            exp_q.push_back(e);
            name_q.push_back("pop_during_push");
        end else if (action == 2) begin
            bus.wen = 1'b1; bus.address = 2'd1;
        end
        @(negedge clk);
        bus.ren = 1'b0;
        bus.wen = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    function automatic logic [7:0] rand_key();
        int r;
        r = $urandom_range(0, 99);
        if (r < 35) return 8'h00;
        if (r < 39) return 8'h01;
        if (r < 65) return m_prev[$urandom_range(0, 3)];
        if (r < 92) return 8'($urandom_range(4, 'h2f));
        return 8'($urandom);
    endfunction

    // Monitor: one cycle after a read strobe data_out must match the prediction,
    // otherwise it must hold the last predicted value.
    initial begin : monitor
        logic [31:0] last, e;
        string       n;
        bit          fire;
        last = 32'h0;
        forever begin
            @(posedge clk);
            fire = bus.ren;
            @(negedge clk);
            if (!reset) begin
                last = 32'h0;
            end else if (fire) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_read", bus.data_out, last);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    $display("read %-24s data_out=%08h expected=%08h", n, bus.data_out, e);
                    check(n, bus.data_out, e);
                    last = e;
                end
            end else begin
                check("data_out_hold", bus.data_out, last);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stimulus
        int          remaining;
        logic [7:0]  base;
        logic [7:0]  ks[4];
        logic [1:0]  t;
        int          op;

        bus.ren = 1'b0; bus.wen = 1'b0; bus.address = 2'd0;
        report = 1'b0; typ = 2'd0; key_modifiers = 8'h0;
        key1 = 8'h0; key2 = 8'h0; key3 = 8'h0; key4 = 8'h0;
        model_reset();
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data_out", bus.data_out, 32'h0);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);

        rd_const(2'd1, 32'h0000_0001, "reset_status");
        rd_const(2'd2, 32'h0000_0000, "reset_mods");
        rd_const(2'd3, 32'h0000_0000, "reset_drops");
        rd_const(2'd0, 32'h0000_0000, "empty_read");

        send(2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 0);
        rd_const(2'd0, 32'h8000_0461, "first_press_a");

        send(2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 0);
        send(2'd1, 8'h02, 8'h04, 8'h05, 8'h00, 8'h00, 0);
        rd_const(2'd0, 32'h8002_0542, "shifted_b");
        rd_const(2'd1, 32'h0000_0001, "only_one_new");

        send(2'd1, 8'h00, 8'h04, 8'h05, 8'h01, 8'h00, 0);
        send(2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 0);
        rd_const(2'd1, 32'h0000_0001, "rollover_and_held");
        rd_const(2'd2, 32'h0000_0000, "mods_latest");

        send(2'd2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        remaining = DEPTH + 3;
        base = 8'h04;
        while (remaining > 0) begin
            for (int s = 0; s < 4; s++) ks[s] = (s < remaining) ? base + 8'(s) : 8'h00;
            send(2'd1, 8'h20, ks[0], ks[1], ks[2], ks[3], 0);
            remaining -= (remaining < 4) ? remaining : 4;
            base = (base == 8'h04) ? 8'h14 : 8'h04;
        end
        rd_const(2'd1, 32'h0000_1006, "full_overflow_status");
        rd_const(2'd3, 32'h0000_0003, "drop_count");

        send(2'd1, 8'h00, 8'h2c, 8'h00, 8'h00, 8'h00, 1);
        rd_const(2'd1, 32'h0000_1006, "full_after_pop_push");
        rd_const(2'd3, 32'h0000_0003, "no_drop_on_pop_push");

        wr(2'd1);
        rd_const(2'd1, 32'h0000_0001, "flush_status");
        rd_const(2'd3, 32'h0000_0000, "flush_drops");

        send(2'd1, 8'h00, 8'h28, 8'h00, 8'h00, 8'h00, 2);
        rd_const(2'd1, 32'h0000_0001, "flush_beats_push");

        for (int it = 0; it < 90; it++) begin
            op = $urandom_range(0, 9);
            if (op < 5) begin
                t = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
                send(t, 8'($urandom), rand_key(), rand_key(), rand_key(), rand_key(),
                     $urandom_range(0, 3) == 0 ? 1 : 0);
            end else if (op < 9) begin
                rd(2'($urandom_range(0, 3)), "random_read");
            end else begin
                wr(2'($urandom_range(0, 3)));
            end
        end
        for (int i = 0; i < DEPTH + 2; i++) rd(2'd0, "drain_read");
        rd(2'd1, "drain_status");

        send(2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 0);
        rd_const(2'd0, 32'h8000_0461, "pre_reset_press");
        @(negedge clk);
        report = 1'b1; typ = 2'd1; key_modifiers = 8'h22;
        key1 = 8'h06; key2 = 8'h07; key3 = 8'h08; key4 = 8'h00;
        @(negedge clk);
        report = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("reset_mid_scan_data", bus.data_out, 32'h0);
        #2 reset = 1'b1;
        model_reset();
        repeat (10) @(negedge clk);
        rd_const(2'd1, 32'h0000_0001, "post_reset_status");
        rd_const(2'd2, 32'h0000_0000, "post_reset_mods");
        rd_const(2'd3, 32'h0000_0000, "post_reset_drops");
        rd_const(2'd0, 32'h0000_0000, "post_reset_empty");
        send(2'd1, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 0);
        rd_const(2'd0, 32'h8000_0461, "prev_cleared_by_reset");

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_expectations actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
